// File: rtl/sw_debounce_pkg.sv
// ---------------------------------------------------------------------------
// sw_debounce_pkg
// Shared constants and types for the slide-switch debouncer.
//   SW_WIDTH          default number of switch bits (8 data + 1 enable)
//   SW_STABLE_CYCLES  default number of consecutive cycles before a level is accepted
//   SW_CNT_W          default counter width (2**SW_CNT_W > SW_STABLE_CYCLES)
//   deb_state_t       per-bit debounce state (stable / change pending)
// ---------------------------------------------------------------------------
package sw_debounce_pkg;

  localparam int SW_WIDTH         = 9;
  localparam int SW_STABLE_CYCLES = 50000;
  localparam int SW_CNT_W         = 16;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// ---------------------------------------------------------------------------
// sw_debounce_bit
// One switch bit: 2-flop synchroniser, stability counter and a two-state FSM.
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous reset, active low
//   sw_raw  in   raw switch level, asynchronous to clk
//   clean   out  debounced level (registered)
//   accept  out  combinational strobe: clean takes the synchronised level
//                at the coming clock edge
// ---------------------------------------------------------------------------
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = SW_STABLE_CYCLES,
  parameter int CNT_W         = SW_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic clean,
  output logic accept
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_reg;
  logic             sync2_reg;
  deb_state_t       state_reg;
  deb_state_t       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             clean_reg;
  logic             clean_next;

  // Plain flop-to-flop synchroniser; nothing may sit between the two stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= sw_raw;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_STABLE;
      cnt_reg   <= '0;
      clean_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      clean_reg <= clean_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clean_next = clean_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_STABLE: begin
        cnt_next = '0;
        if (sync2_reg != clean_reg) begin
          state_next = ST_PENDING;
          cnt_next   = CNT_ONE;
        end
      end
      ST_PENDING: begin
        if (sync2_reg == clean_reg) begin
          // Level went back before qualifying: drop the candidate.
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
          clean_next = sync2_reg;
          accept     = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_STABLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign clean = clean_reg;

endmodule

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// Conditions raw slide switches for the 8-3 priority encoder: synchronises
// and debounces every bit independently, and flags each accepted change.
// Optional feature macro: SW_DEBOUNCE_EDGE_EN adds per-bit rise/fall pulses.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active low (0 = reset)
//   sw_raw      in   [WIDTH] raw board switches, asynchronous to clk
//   sw_clean    out  [WIDTH] debounced switch vector
//   sw_changed  out  1-cycle pulse when any sw_clean bit updates
//   sw_rise     out  [WIDTH] per-bit 0->1 accept pulse (SW_DEBOUNCE_EDGE_EN)
//   sw_fall     out  [WIDTH] per-bit 1->0 accept pulse (SW_DEBOUNCE_EDGE_EN)
// ---------------------------------------------------------------------------
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = SW_STABLE_CYCLES,
  parameter int CNT_W         = SW_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic             sw_changed
`ifdef SW_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
`endif
);

  logic [WIDTH-1:0] accept_vec;
  logic             changed_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      sw_debounce_bit #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
      ) u_bit (
        .clk    (clk),
        .rst    (rst),
        .sw_raw (sw_raw[gi]),
        .clean  (sw_clean[gi]),
        .accept (accept_vec[gi])
      );
    end
  endgenerate

  // Registering the OR of the combinational accepts lines the pulse up with
  // the clean-level flops, which update on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= |accept_vec;
    end
  end

  assign sw_changed = changed_reg;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] fall_reg;

  // The old clean level decides the direction of the change being accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_reg <= '0;
      fall_reg <= '0;
    end else begin
      rise_reg <= accept_vec & ~sw_clean;
      fall_reg <= accept_vec & sw_clean;
    end
  end

  assign sw_rise = rise_reg;
  assign sw_fall = fall_reg;
`endif

endmodule
